decode_stage_fwd: RTL
=====================

Name: decode_stage_fwd

Overview:
- Parametrised decode/register-read stage for the MIPS pipeline.
- Holds the IF/ID pipeline register and an internal register file with write-through bypass.
- Resolves operands through an N-source priority forwarding network.
- Raises a load-use hazard stall itself; the forwarding unit does not supply ready-made operands.
- Sits between stage_fetch and stage_execute and generalises the fixed two-operand decode stage.

Parameters:
WIDTH, 32, data/PC width in bits.
REGS, 32, architectural register count; address width AW = $clog2(REGS), fixed at 5 for REGS=32.
READ_PORTS, 2, operand ports 1..3; port0=rs instr[25:21], port1=rt instr[20:16], port2=rd instr[15:11].
FWD_SRCS, 2, forwarding sources; index 0 has the highest priority (execute), then memory.
CNT_W, 16, width of the hazard-cycle statistics counter.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-low reset.
in_valid  in  1  fetch slot holds a real instruction.
in_instr  in  32  fetched instruction.
in_pc  in  WIDTH  fetched PC.
stall  in  1  external hold of the stage register.
nullify  in  1  insert a bubble (branch flush).
wb_we  in  1  writeback enable.
wb_addr  in  AW  writeback register.
wb_data  in  WIDTH  writeback data.
fwd_valid  in  FWD_SRCS  source i will write fwd_addr[i].
fwd_ready  in  FWD_SRCS  source i data is available this cycle (0 = load still pending).
fwd_addr  in  FWD_SRCS*AW  packed destination registers.
fwd_data  in  FWD_SRCS*WIDTH  packed forward data.
out_valid  out  1  decoded slot valid.
out_instr  out  32  registered instruction.
out_pc  out  WIDTH  registered PC.
out_pcadd4  out  WIDTH  out_pc + 4.
out_opnd  out  READ_PORTS*WIDTH  packed resolved operands.
hazard_stall  out  1  request to stall fetch/decode and bubble execute.
hazard_cnt  out  CNT_W  saturating count of hazard cycles.

Behaviour:
- Reset (reset==0 at a posedge):
  - out_valid=0, out_instr=0, out_pc=0; out_pcadd4 therefore reads 4.
  - All registers cleared to 0; hazard_cnt=0.
  - Reset wins over stall, nullify and wb_we.
- Stage register update at each posedge, in priority order:
  - nullify=1: valid=0, instr=0, pc keeps its old value. nullify wins over stall and hazard.
  - else stall=1 or hazard_stall=1: hold all fields.
  - else: capture in_valid, in_instr, in_pc.
- Latency: one cycle from in_* to out_instr/out_pc. Operands are combinational from the registered instruction.
- Register file:
  - Write on posedge when wb_we=1 and wb_addr!=0.
  - Register 0 reads 0 and is never written.
  - Writes are independent of stall and nullify.
- Operand resolution per port p, with address a taken from the registered instr:
  1. a==0: operand 0, no hazard.
  2. Lowest index i with fwd_valid[i] && fwd_addr[i]==a:
     - fwd_ready[i]=1: fwd_data[i].
     - fwd_ready[i]=0: hazard on port p; operand value don't-care.
     - Lower-priority matches are ignored, even if they are ready.
  3. Else wb_we && wb_addr==a: wb_data (write-through, same cycle).
  4. Else register file contents.
- hazard_stall = out_valid && OR of port hazards. It is purely combinational and does not depend on stall.
- hazard_cnt increments by 1 on every posedge with hazard_stall=1, saturates at 2^CNT_W-1, and is never cleared except by reset.
- out_pcadd4 = out_pc + 4, modulo 2^WIDTH, so it wraps at the top of the address space.
- Ports beyond READ_PORTS do not exist; READ_PORTS=3 adds the rd port with identical rules.

Test Plan:
1. Write/read with bypass: write r5=0xDEADBEEF; decode add rs=5 rt=0 -> opnd0=0xDEADBEEF, opnd1=0. Same-cycle wb r6=0x1234 with instr rs=6 -> opnd0=0x1234 in that cycle.
2. Forward priority: fwd0 (r3, 0xAAAA, ready) and fwd1 (r3, 0xBBBB, ready) -> opnd0=0xAAAA. With fwd0 invalid -> 0xBBBB.
3. Load-use hazard: fwd0 valid, r7, ready=0; decoded rt=7 -> hazard_stall=1 and stage holds for 3 cycles, hazard_cnt=3. Then ready=1, fwd_data=0x55 -> opnd1=0x55, hazard_stall=0, next instruction captured.
4. Ready lower source does not mask a pending higher one: fwd0 r4 not ready, fwd1 r4 ready -> hazard_stall=1.
5. Flush priority: stall=1 and nullify=1 together -> out_valid=0, out_instr=0 next cycle. A pending hazard on the nullified slot -> hazard_stall=0.
6. Reset mid-operation: reset low while stall=1, r9=0x77, hazard_cnt=5 -> next cycle out_valid=0, out_pcadd4=4, r9 reads 0, hazard_cnt=0. Separately, out_pc=0xFFFFFFFC -> out_pcadd4=0.

Source files
------------

// File: rtl/decode_stage_fwd_if.sv
// Bundle of the decode stage's fetch-side, writeback, forwarding and decoded-output signals.
// The slave modport belongs to the decode stage and the master modport to whatever drives it.
interface decode_stage_fwd_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REGS       = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned FWD_SRCS   = 2,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned AW = (REGS > 1) ? $clog2(REGS) : 1;

  logic                           in_valid;
  logic [31:0]                    in_instr;
  logic [WIDTH-1:0]               in_pc;
  logic                           stall;
  logic                           nullify;
  logic                           wb_we;
  logic [AW-1:0]                  wb_addr;
  logic [WIDTH-1:0]               wb_data;
  logic [FWD_SRCS-1:0]            fwd_valid;
  logic [FWD_SRCS-1:0]            fwd_ready;
  logic [FWD_SRCS*AW-1:0]         fwd_addr;
  logic [FWD_SRCS*WIDTH-1:0]      fwd_data;
  logic                           out_valid;
  logic [31:0]                    out_instr;
  logic [WIDTH-1:0]               out_pc;
  logic [WIDTH-1:0]               out_pcadd4;
  logic [READ_PORTS*WIDTH-1:0]    out_opnd;
  logic                           hazard_stall;
  logic [CNT_W-1:0]               hazard_cnt;

  modport master (
    output in_valid, in_instr, in_pc, stall, nullify,
    output wb_we, wb_addr, wb_data,
    output fwd_valid, fwd_ready, fwd_addr, fwd_data,
    input  out_valid, out_instr, out_pc, out_pcadd4, out_opnd,
    input  hazard_stall, hazard_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc, stall, nullify,
    input  wb_we, wb_addr, wb_data,
    input  fwd_valid, fwd_ready, fwd_addr, fwd_data,
    output out_valid, out_instr, out_pc, out_pcadd4, out_opnd,
    output hazard_stall, hazard_cnt
  );
endinterface

// File: rtl/decode_stage_fwd.sv
// Decode/register-read stage: IF/ID register, register file with write-through,
// priority forwarding network and load-use hazard detection with a statistics counter.
module decode_stage_fwd #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REGS       = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned FWD_SRCS   = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  decode_stage_fwd_if.slave bus
);
  localparam int unsigned AW = (REGS > 1) ? $clog2(REGS) : 1;

  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rf_q [REGS];

  logic [AW-1:0]               raddr [READ_PORTS];
  logic [READ_PORTS-1:0]       port_haz;
  logic [READ_PORTS*WIDTH-1:0] opnd;
  logic                        found;
  logic [WIDTH-1:0]            val;
  logic                        hazard;

  // Port p reads the 5-bit field at instr[25-5p -: 5] (rs, rt, rd).
  always_comb begin
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      raddr[p] = AW'(instr_q[25 - 5*p -: 5]);
    end
  end

  // First matching forwarding source decides the port, even when it is not ready;
  // that is what keeps a ready lower-priority source from masking a pending load.
  always_comb begin
    port_haz = '0;
    opnd     = '0;
    found    = 1'b0;
    val      = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      found = 1'b0;
      val   = rf_q[raddr[p]];
      if (raddr[p] == '0) begin
        found = 1'b1;
        val   = '0;
      end else begin
        for (int unsigned i = 0; i < FWD_SRCS; i++) begin
          if (!found && bus.fwd_valid[i] && (bus.fwd_addr[i*AW +: AW] == raddr[p])) begin
            found = 1'b1;
            if (bus.fwd_ready[i]) begin
              val = bus.fwd_data[i*WIDTH +: WIDTH];
            end else begin
              port_haz[p] = 1'b1;
            end
          end
        end
        if (!found && bus.wb_we && (bus.wb_addr == raddr[p])) begin
          val = bus.wb_data;
        end
      end
      opnd[p*WIDTH +: WIDTH] = val;
    end
  end

  assign hazard = valid_q && (|port_haz);

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (bus.nullify) begin
      valid_d = 1'b0;
      instr_d = '0;
    end else if (!(bus.stall || hazard)) begin
      valid_d = bus.in_valid;
      instr_d = bus.in_instr;
      pc_d    = bus.in_pc;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned r = 0; r < REGS; r++) begin
        rf_q[r] <= '0;
      end
    end else if (bus.wb_we && (bus.wb_addr != '0)) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_instr    = instr_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_pcadd4   = pc_q + WIDTH'(4);
  assign bus.out_opnd     = opnd;
  assign bus.hazard_stall = hazard;
  assign bus.hazard_cnt   = cnt_q;
endmodule
